led_button_ctrl: RTL and testbench
==================================

# led_button_ctrl

Controller between the four active-low board push-buttons and the four user LEDs. It synchronises and debounces the keys, produces clean level and press-event signals, and drives the LED bank from a 4-mode state machine (direct, toggle, chase, count). Software can take over the LED bank at any time. It replaces direct key-to-LED wiring at the board top level and exposes debounced key state to the SoC.

## Interface

- `DEBOUNCE_CYCLES`, default 250000: number of consecutive cycles a synchronised key must differ from its debounced state before that state flips; minimum 2.
- `STEP_CYCLES`, default 3000000: period, in cycles, of one chase/count step; minimum 2.
- `clk` input, 1 bit: single system clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `key_n` input, 4 bits: raw buttons, 0 = pressed, asynchronous to `clk`; bit 0 = D7, bit 1 = C7, bit 2 = T2, bit 3 = T3.
- `sw_en` input, 1 bit: 1 = software owns the LED bank.
- `sw_leds` input, 4 bits: LED value used while `sw_en` = 1.
- `leds` output, 4 bits: registered LED drive, 1 = lit; bit i drives LED2+i.
- `pressed` output, 4 bits: debounced key level, 1 = held.
- `press_evt` output, 4 bits: one-cycle pulse on each debounced press.
- `mode` output, 2 bits: current mode; 0 DIRECT, 1 TOGGLE, 2 CHASE, 3 COUNT.

## Operation

- **Synchroniser:** each `key_n` bit passes through 2 flops, then is inverted to active-high. Reset value of the flops is 1, so the key reads as released.
- **Debounce:** each key has a counter sized for `DEBOUNCE_CYCLES`.
  - The counter clears whenever the synced level equals `pressed[i]`.
  - Otherwise it increments. On the `DEBOUNCE_CYCLES`-th consecutive differing sample, `pressed[i]` flips and the counter clears.
- **press_evt[i]:** asserted for exactly the cycle in which `pressed[i]` goes 0→1. There is no event on release.
- **Mode advance:** a `press_evt[3]` while `pressed[0]` = 1 sets `mode` to `mode`+1 mod 4 (3 wraps to 0).
  - This event is consumed and has no other effect.
  - On every mode entry: toggle latch = 0000, chase position = 0001, direction = up, count = 0, step timer = 0, paused = 0.
- **DIRECT:** `leds` = `pressed`.
- **TOGGLE:** each unconsumed `press_evt[i]` inverts latch bit i; `leds` = latch. Simultaneous events on several keys invert all of those bits in the same cycle.
- **CHASE:**
  - One lit LED, starting at 0001.
  - At each step it rotates left (up: 0001→0010→0100→1000→0001) or right (down).
  - `press_evt[1]` reverses direction, effective from the next step.
- **COUNT:**
  - `leds` = 4-bit count, which increments at each step and wraps 1111→0000.
  - `press_evt[1]` clears count to 0 and the step timer to 0.
- **Pause (CHASE and COUNT):** `press_evt[2]` toggles paused. While paused, the step timer holds and the LEDs freeze.
- **Step timer:** counts 0..`STEP_CYCLES`-1. At the cycle it wraps to 0, a step occurs.
- **Software override:** while `sw_en` = 1, `leds` = `sw_leds`.
  - The mode FSM, latches and timer keep running underneath.
  - Clearing `sw_en` restores FSM output on the next cycle.
- **Same-cycle priority:** mode advance beats all other actions; `press_evt[1]` clear beats a step.
- **Reset:** reset at any point, including mid-debounce or mid-step, returns everything to reset values on the next edge.

## Timing

- **Reset values:**
  - `leds` = 0000, `pressed` = 0000, `press_evt` = 0000, `mode` = 0 (DIRECT).
  - All counters = 0, latch = 0000, chase position = 0001, direction up, not paused.
- **Press latency:** with a clean press whose low level is first sampled at edge k, `pressed[i]` and `press_evt[i]` rise at edge k+1+`DEBOUNCE_CYCLES`. Release latency is identical.
- **Glitch rejection:** a pulse shorter than `DEBOUNCE_CYCLES` cycles at the synchroniser output never changes `pressed`. Any bounce back to the debounced level restarts the count.
- **LED latency:** `leds` reflects `pressed`, a `press_evt` or a step exactly one cycle later.
- **Mode latency:** `mode` updates one cycle after the advance event.
- **Step spacing:** while unpaused, chase/count steps occur exactly every `STEP_CYCLES` cycles. The first step occurs `STEP_CYCLES` cycles after mode entry.
- **Override latency:** `sw_en` and `sw_leds` reach `leds` in one cycle.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `STEP_CYCLES`=8.

1. **Reset defaults.** Assert reset for 3 cycles mid-operation → `leds`=0000, `pressed`=0000, `mode`=0. A key held through reset yields `press_evt` only after the full debounce following reset release.
2. **Debounce.** Drive `key_n[1]` low for 3 cycles then high → no `pressed` change. Drive it low and hold → `press_evt`=0010 for one cycle at sample+5, and `leds`=0010 one cycle later in DIRECT.
3. **Toggle mode.**
   - Hold key0, press key3 → `mode`=1, `leds`=0000.
   - Press key2 twice → `leds` goes 0100 then 0000.
   - Press key1 and key2 on the same cycle → `leds`=0110.
4. **Chase mode.**
   - Advance to `mode`=2 → `leds` 0001, 0010, 0100, 1000, 0001 at 8-cycle spacing.
   - Press key1 at 0100 → next steps 0010, 0001, 1000.
   - Press key2 → `leds` frozen for 40 cycles.
5. **Count mode and wrap.**
   - From mode 2, advance to `mode`=3 → count 0..15, then 0 at 8-cycle spacing.
   - Press key1 on a step cycle → `leds`=0000 and the next step 8 cycles later.
   - One more advance → `mode`=0.
6. **Software override.** Set `sw_en`=1, `sw_leds`=1010 in COUNT → `leds`=1010 next cycle. Release after 20 cycles → `leds` shows the advanced count.

Source files
------------

// File: rtl/led_button_ctrl.sv
// Push-button front end (2-flop sync, per-key debounce, press events) feeding a
// four-mode LED state machine, with a software override of the LED bank.
module led_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STEP_CYCLES     = 3000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       sw_en,
    input  logic [3:0] sw_leds,
    output logic [3:0] leds,
    output logic [3:0] pressed,
    output logic [3:0] press_evt,
    output logic [1:0] mode
);
    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned     ST_W    = $clog2(STEP_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    logic [3:0]      sync1_q, sync2_q, key_lvl_s;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];
    logic [3:0]      pressed_q, pressed_d, evt_q, evt_d;

    mode_e           mode_q, mode_d;
    logic [3:0]      latch_q, latch_d, pos_q, pos_d, count_q, count_d;
    logic [3:0]      leds_q, leds_d, fsm_leds_s;
    logic            dir_up_q, dir_up_d, paused_q, paused_d;
    logic [ST_W-1:0] timer_q, timer_d;
    logic            advance_s, step_s;

    // Two-flop synchroniser; raw keys idle high, so reset reads as released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign key_lvl_s = ~sync2_q;

    // Debounce: flip after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        pressed_d = pressed_q;
        evt_d     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (key_lvl_s[i] == pressed_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                pressed_d[i] = key_lvl_s[i];
                evt_d[i]     = key_lvl_s[i];
                db_cnt_d[i]  = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pressed_q <= 4'b0000;
            evt_q     <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            pressed_q <= pressed_d;
            evt_q     <= evt_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign advance_s = evt_q[3] & pressed_q[0];
    assign step_s    = ~paused_q & (timer_q == ST_LAST);

    // Mode FSM next state; an advance resets all per-mode state and swallows the event.
    always_comb begin
        mode_d   = mode_q;
        latch_d  = latch_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        count_d  = count_q;
        timer_d  = timer_q;
        paused_d = paused_q;
        if (advance_s) begin
            mode_d   = mode_e'(mode_q + 2'd1);
            latch_d  = 4'b0000;
            pos_d    = 4'b0001;
            dir_up_d = 1'b1;
            count_d  = 4'd0;
            timer_d  = '0;
            paused_d = 1'b0;
        end else begin
            if (paused_q) begin
                timer_d = timer_q;
            end else if (step_s) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + ST_W'(1);
            end
            case (mode_q)
                MODE_TOGGLE: latch_d = latch_q ^ evt_q;
                MODE_CHASE: begin
                    if (step_s) begin
                        pos_d = dir_up_q ? {pos_q[2:0], pos_q[3]} : {pos_q[0], pos_q[3:1]};
                    end else begin
                        pos_d = pos_q;
                    end
                    dir_up_d = dir_up_q ^ evt_q[1];
                    paused_d = paused_q ^ evt_q[2];
                end
                MODE_COUNT: begin
                    // A clear beats a coincident step and restarts the step period.
                    if (evt_q[1]) begin
                        count_d = 4'd0;
                        timer_d = '0;
                    end else if (step_s) begin
                        count_d = count_q + 4'd1;
                    end else begin
                        count_d = count_q;
                    end
                    paused_d = paused_q ^ evt_q[2];
                end
                default: latch_d = latch_q;
            endcase
        end
    end

    // LED drive from the next FSM state so events and steps show one cycle later.
    always_comb begin
        fsm_leds_s = 4'b0000;
        case (mode_d)
            MODE_DIRECT: fsm_leds_s = pressed_q;
            MODE_TOGGLE: fsm_leds_s = latch_d;
            MODE_CHASE:  fsm_leds_s = pos_d;
            MODE_COUNT:  fsm_leds_s = count_d;
            default:     fsm_leds_s = 4'b0000;
        endcase
        if (sw_en) begin
            leds_d = sw_leds;
        end else begin
            leds_d = fsm_leds_s;
        end
    end

    // Mode FSM and LED registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= MODE_DIRECT;
            latch_q  <= 4'b0000;
            pos_q    <= 4'b0001;
            dir_up_q <= 1'b1;
            count_q  <= 4'd0;
            timer_q  <= '0;
            paused_q <= 1'b0;
            leds_q   <= 4'b0000;
        end else begin
            mode_q   <= mode_d;
            latch_q  <= latch_d;
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            paused_q <= paused_d;
            leds_q   <= leds_d;
        end
    end

    assign leds      = leds_q;
    assign pressed   = pressed_q;
    assign press_evt = evt_q;
    assign mode      = mode_q;

endmodule

// File: tb/tb_led_button_ctrl.sv
// Self-checking bench for led_button_ctrl: directed scenarios with literal
// expectations plus a random phase, all cross-checked every cycle against a model.
module tb_led_button_ctrl;
    localparam int DB = 4;
    localparam int ST = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic       sw_en;
    logic [3:0] sw_leds;
    logic [3:0] leds, pressed, press_evt;
    logic [1:0] mode;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: key history, run lengths, and mode state in plain integers.
    logic [3:0] m_s1, m_s2, m_pressed, m_evt, m_latch, m_leds;
    int         m_run [4];
    int         m_mode, m_idx, m_cnt, m_timer;
    bit         m_up, m_paused;

    led_button_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP_CYCLES(ST)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .sw_en(sw_en), .sw_leds(sw_leds),
        .leds(leds), .pressed(pressed), .press_evt(press_evt), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] lvl;
        logic [3:0] fsm;
        bit         stepping;
        if (reset) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_pressed = 4'h0; m_evt = 4'h0;
            m_latch = 4'h0; m_leds = 4'h0; m_mode = 0; m_idx = 0; m_cnt = 0;
            m_timer = 0; m_up = 1'b1; m_paused = 1'b0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            lvl = ~m_s2;
            if (m_evt[3] && m_pressed[0]) begin
                m_mode = (m_mode + 1) % 4;
                m_latch = 4'h0; m_idx = 0; m_up = 1'b1; m_cnt = 0; m_timer = 0; m_paused = 1'b0;
            end else begin
                stepping = !m_paused && (m_timer == ST - 1);
                if (!m_paused) m_timer = (m_timer + 1) % ST;
                if (m_mode == 1) begin
                    m_latch = m_latch ^ m_evt;
                end else if (m_mode == 2) begin
                    if (stepping) m_idx = m_up ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
                    if (m_evt[1]) m_up = !m_up;
                    if (m_evt[2]) m_paused = !m_paused;
                end else if (m_mode == 3) begin
                    if (m_evt[1]) begin
                        m_cnt = 0;
                        m_timer = 0;
                    end else if (stepping) begin
                        m_cnt = (m_cnt + 1) % 16;
                    end
                    if (m_evt[2]) m_paused = !m_paused;
                end
            end
            case (m_mode)
                0:       fsm = m_pressed;
                1:       fsm = m_latch;
                2:       fsm = 4'(1 << m_idx);
                default: fsm = 4'(m_cnt);
            endcase
            m_leds = sw_en ? sw_leds : fsm;
            for (int i = 0; i < 4; i++) begin
                m_evt[i] = 1'b0;
                if (lvl[i] == m_pressed[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_pressed[i] = lvl[i];
                        m_evt[i] = lvl[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_leds", leds, m_leds);
        check("model_pressed", pressed, m_pressed);
        check("model_evt", press_evt, m_evt);
        check("model_mode", {2'b00, mode}, 4'(m_mode));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_mode(input logic [1:0] target);
        int k;
        k = 0;
        while (mode !== target && k < 40) begin
            tick();
            k++;
        end
        check("wait_mode", {2'b00, mode}, {2'b00, target});
    endtask

    initial begin
        reset = 1'b1; key_n = 4'hF; sw_en = 1'b0; sw_leds = 4'h0;
        ticks(3);
        check("rst_leds", leds, 4'b0000);
        check("rst_pressed", pressed, 4'b0000);
        check("rst_mode", {2'b00, mode}, 4'd0);
        reset = 1'b0;
        ticks(2);

        // Glitch shorter than the debounce window, then a clean press.
        key_n = 4'b1101; ticks(3);
        key_n = 4'b1111; ticks(10);
        check("glitch_pressed", pressed, 4'b0000);
        key_n = 4'b1101; ticks(5);
        check("evt_early", press_evt, 4'b0000);
        tick();
        check("evt_k5", press_evt, 4'b0010);
        check("leds_lag", leds, 4'b0000);
        tick();
        check("evt_one_cycle", press_evt, 4'b0000);
        check("direct_leds", leds, 4'b0010);
        key_n = 4'b1111; ticks(10);
        check("direct_release", leds, 4'b0000);

        // TOGGLE
        key_n = 4'b1110; ticks(10);
        key_n = 4'b0110; ticks(10);
        check("toggle_mode", {2'b00, mode}, 4'd1);
        check("toggle_entry", leds, 4'b0000);
        key_n = 4'b1111; ticks(10);
        key_n = 4'b1011; ticks(10);
        check("toggle_k2a", leds, 4'b0100);
        key_n = 4'b1111; ticks(10);
        check("toggle_rel", leds, 4'b0100);
        key_n = 4'b1011; ticks(10);
        check("toggle_k2b", leds, 4'b0000);
        key_n = 4'b1111; ticks(10);
        key_n = 4'b1001; ticks(10);
        check("toggle_k12", leds, 4'b0110);
        key_n = 4'b1111; ticks(10);

        // CHASE
        key_n = 4'b1110; ticks(10);
        key_n = 4'b0110; wait_mode(2'd2);
        check("chase_entry", leds, 4'b0001);
        key_n = 4'b1111;
        ticks(8); check("chase_1", leds, 4'b0010);
        ticks(8); check("chase_2", leds, 4'b0100);
        key_n = 4'b1101;
        ticks(8); check("chase_rev1", leds, 4'b0010);
        key_n = 4'b1111;
        ticks(8); check("chase_rev2", leds, 4'b0001);
        ticks(8); check("chase_rev3", leds, 4'b1000);
        key_n = 4'b1011; ticks(8);
        check("pause_entry", leds, 4'b1000);
        key_n = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("pause_frozen", leds, 4'b1000);
        end
        key_n = 4'b1011; ticks(10);
        key_n = 4'b1111; ticks(10);

        // COUNT
        key_n = 4'b1110; ticks(10);
        key_n = 4'b0110; wait_mode(2'd3);
        check("count_entry", leds, 4'b0000);
        key_n = 4'b1111;
        for (int i = 1; i <= 16; i++) begin
            ticks(8);
            check("count_step", leds, 4'(i));
        end
        tick();
        key_n = 4'b1101; ticks(6);
        check("clear_evt", press_evt, 4'b0010);
        tick();
        check("clear_beats_step", leds, 4'b0000);
        key_n = 4'b1111; ticks(7);
        check("clear_hold", leds, 4'b0000);
        tick();
        check("clear_next_step", leds, 4'b0001);

        // Software override
        sw_leds = 4'b1010; sw_en = 1'b1; tick();
        check("sw_first", leds, 4'b1010);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sw_hold", leds, 4'b1010);
        end
        sw_en = 1'b0; tick();
        check("sw_release", leds, 4'b0011);

        key_n = 4'b1110; ticks(10);
        key_n = 4'b0110; wait_mode(2'd0);
        key_n = 4'b1111; ticks(10);

        // Reset mid-operation with keys held through it
        key_n = 4'b1010; ticks(10);
        check("pre_reset_leds", leds, 4'b0101);
        reset = 1'b1; ticks(3);
        check("mid_rst_leds", leds, 4'b0000);
        check("mid_rst_pressed", pressed, 4'b0000);
        check("mid_rst_evt", press_evt, 4'b0000);
        check("mid_rst_mode", {2'b00, mode}, 4'd0);
        reset = 1'b0; ticks(5);
        check("held_evt_early", press_evt, 4'b0000);
        tick();
        check("held_evt", press_evt, 4'b0101);
        key_n = 4'b1111; ticks(10);

        // Random phase
        for (int c = 0; c < 6000; c++) begin
            int kb;
            if ($urandom_range(0, 11) == 0) begin
                kb = $urandom_range(0, 3);
                key_n[kb] = ~key_n[kb];
            end
            if ($urandom_range(0, 49) == 0) sw_en = ~sw_en;
            if ($urandom_range(0, 3) == 0) sw_leds = 4'($urandom);
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
